// File: rtl/disp_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : disp_src_arbiter
// Purpose  : Display-source arbiter for the BCD / 7-segment path. Chooses one
//            of NCH channels on a load pulse (highest index wins). It keeps a
//            registered snapshot of that channel's value and offers each new
//            snapshot to the BCD converter over a valid/ready handshake. After
//            HOLD_CYC idle cycles it can revert to channel DEF_CH.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-high reset
//            ch_data    - packed channel values, channel i = ch_data[i*W +: W]
//            ch_load    - per-channel one-cycle "value final" pulse
//            upd_ready  - BCD converter can accept an update
//            numero_out - registered snapshot of the selected channel
//            sel_ch     - index of the channel currently shown
//            upd_valid  - new value pending for the BCD converter
//            overrun    - sticky: a pending update was overwritten
// Revision : 1.0 - initial release
// ============================================================================
module disp_src_arbiter #(
    parameter int NCH      = 3,
    parameter int W        = 16,
    parameter int DEF_CH   = 0,
    parameter int HOLD_CYC = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH*W-1:0]       ch_data,
    input  logic [NCH-1:0]         ch_load,
    input  logic                   upd_ready,
    output logic [W-1:0]           numero_out,
    output logic [$clog2(NCH)-1:0] sel_ch,
    output logic                   upd_valid,
    output logic                   overrun
);

    localparam int c_SEL_W = $clog2(NCH);
    // The counter only needs to reach HOLD_CYC. One bit is kept when revert is disabled.
    localparam int c_CNT_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;

    localparam logic [c_SEL_W-1:0] c_DEF_SEL  = c_SEL_W'(DEF_CH);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'((HOLD_CYC > 0) ? HOLD_CYC : 0);
    localparam logic [c_CNT_W-1:0] c_HOLD_M1  = c_CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PEND = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [W-1:0]       r_numero;
    logic [c_SEL_W-1:0] r_sel;
    logic               r_overrun;
    logic [c_CNT_W-1:0] r_idle_cnt;
    logic [c_CNT_W-1:0] w_idle_cnt_nxt;

    logic               w_load_any;
    logic [c_SEL_W-1:0] w_load_idx;
    logic [W-1:0]       w_load_data;
    logic [W-1:0]       w_def_data;
    logic               w_cnt_eligible;
    logic               w_timeout;
    logic               w_upd_valid;

    // Priority encoder. The ascending loop lets the highest set index win.
    always_comb begin
        w_load_idx  = '0;
        w_load_data = ch_data[W-1:0];
        for (int i = 0; i < NCH; i++) begin
            if (ch_load[i]) begin
                w_load_idx  = c_SEL_W'(i);
                w_load_data = ch_data[i*W +: W];
            end
        end
    end

    assign w_load_any = |ch_load;
    assign w_def_data = ch_data[DEF_CH*W +: W];

    // The idle timer runs only while the display is parked on a non-default
    // channel with nothing pending. The revert fires on the cycle that would
    // bring the count to HOLD_CYC. A load in that same cycle wins.
    assign w_cnt_eligible = (HOLD_CYC > 0) && (r_state == S_IDLE) &&
                            !w_load_any && (r_sel != c_DEF_SEL);
    assign w_timeout      = w_cnt_eligible && (r_idle_cnt == c_HOLD_M1);

    always_comb begin
        w_idle_cnt_nxt = r_idle_cnt;
        if (!w_cnt_eligible || w_timeout) begin
            w_idle_cnt_nxt = '0;
        end else if (r_idle_cnt != c_CNT_MAX) begin
            w_idle_cnt_nxt = r_idle_cnt + 1'b1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_load_any || w_timeout) begin
                    w_state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                if (!w_load_any && upd_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_upd_valid = 1'b0;
        if (r_state == S_PEND) begin
            w_upd_valid = 1'b1;
        end
    end

    // Snapshot, selection, sticky overrun and idle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_numero   <= '0;
            r_sel      <= c_DEF_SEL;
            r_overrun  <= 1'b0;
            r_idle_cnt <= '0;
        end else begin
            if (w_load_any) begin
                r_numero <= w_load_data;
                r_sel    <= w_load_idx;
            end else if (w_timeout) begin
                r_numero <= w_def_data;
                r_sel    <= c_DEF_SEL;
            end
            // Losing a pending value is only an overrun if the converter
            // did not take it in the same cycle.
            if (w_load_any && (r_state == S_PEND) && !upd_ready) begin
                r_overrun <= 1'b1;
            end
            r_idle_cnt <= w_idle_cnt_nxt;
        end
    end

    assign numero_out = r_numero;
    assign sel_ch     = r_sel;
    assign upd_valid  = w_upd_valid;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_disp_src_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_src_arbiter
// Purpose  : Directed self-checking bench for disp_src_arbiter. It uses
//            NCH=3, W=16, DEF_CH=0 and HOLD_CYC=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_src_arbiter;

    localparam int c_NCH = 3;
    localparam int c_W   = 16;

    logic                 clk;
    logic                 rst;
    logic [c_NCH*c_W-1:0] ch_data;
    logic [c_NCH-1:0]     ch_load;
    logic                 upd_ready;
    logic [c_W-1:0]       numero_out;
    logic [1:0]           sel_ch;
    logic                 upd_valid;
    logic                 overrun;

    int tests_run;
    int tests_failed;

    disp_src_arbiter #(
        .NCH      (c_NCH),
        .W        (c_W),
        .DEF_CH   (0),
        .HOLD_CYC (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_data    (ch_data),
        .ch_load    (ch_load),
        .upd_ready  (upd_ready),
        .numero_out (numero_out),
        .sel_ch     (sel_ch),
        .upd_valid  (upd_valid),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_init();
        rst = 1'b1;
        #2;
        tests_run++; if (numero_out !== 16'h0000) begin tests_failed++; $display("FAIL reset_numero got=%h exp=0000", numero_out); end
        tests_run++; if (sel_ch !== 2'd0) begin tests_failed++; $display("FAIL reset_sel got=%0d exp=0", sel_ch); end
        tests_run++; if (upd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", upd_valid); end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        tests_run++; if (upd_valid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_valid got=%b exp=0", upd_valid); end
    endtask

    task automatic test_priority();
        upd_ready = 1'b0;
        ch_data[0*c_W +: c_W] = 16'h0012;
        ch_data[1*c_W +: c_W] = 16'h0099;
        ch_data[2*c_W +: c_W] = 16'h0144;
        ch_load = 3'b101;
        tick();
        ch_load = 3'b000;
        tests_run++; if (sel_ch !== 2'd2) begin tests_failed++; $display("FAIL prio_sel got=%0d exp=2", sel_ch); end
        tests_run++; if (numero_out !== 16'h0144) begin tests_failed++; $display("FAIL prio_numero got=%h exp=0144", numero_out); end
        tests_run++; if (upd_valid !== 1'b1) begin tests_failed++; $display("FAIL prio_valid got=%b exp=1", upd_valid); end
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
        tests_run++; if (upd_valid !== 1'b0) begin tests_failed++; $display("FAIL prio_accept_valid got=%b exp=0", upd_valid); end
    endtask

    task automatic test_handshake();
        ch_data[0*c_W +: c_W] = 16'h0ABC;
        ch_load = 3'b001;
        tick();
        ch_load = 3'b000;
        tests_run++; if (numero_out !== 16'h0ABC) begin tests_failed++; $display("FAIL hs_capture got=%h exp=0abc", numero_out); end
        for (int k = 0; k < 5; k++) begin
            // Changing the source while the value is held must not affect the output.
            ch_data[0*c_W +: c_W] = 16'h1000 + 16'(k);
            tick();
            tests_run++; if (upd_valid !== 1'b1 || numero_out !== 16'h0ABC) begin
                tests_failed++; $display("FAIL hs_hold%0d got valid=%b numero=%h exp valid=1 numero=0abc", k, upd_valid, numero_out);
            end
        end
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
        tests_run++; if (upd_valid !== 1'b0) begin tests_failed++; $display("FAIL hs_accept_valid got=%b exp=0", upd_valid); end
        tests_run++; if (numero_out !== 16'h0ABC) begin tests_failed++; $display("FAIL hs_after_numero got=%h exp=0abc", numero_out); end
    endtask

    task automatic test_overrun();
        ch_data[0*c_W +: c_W] = 16'h0003;
        ch_load = 3'b001;
        tick();
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_pre got=%b exp=0", overrun); end
        ch_data[1*c_W +: c_W] = 16'h0007;
        ch_load = 3'b010;
        tick();
        ch_load = 3'b000;
        tests_run++; if (numero_out !== 16'h0007) begin tests_failed++; $display("FAIL ovr_numero got=%h exp=0007", numero_out); end
        tests_run++; if (sel_ch !== 2'd1) begin tests_failed++; $display("FAIL ovr_sel got=%0d exp=1", sel_ch); end
        tests_run++; if (overrun !== 1'b1 || upd_valid !== 1'b1) begin
            tests_failed++; $display("FAIL ovr_flag got overrun=%b valid=%b exp overrun=1 valid=1", overrun, upd_valid);
        end
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
        tests_run++; if (overrun !== 1'b1 || upd_valid !== 1'b0) begin
            tests_failed++; $display("FAIL ovr_sticky got overrun=%b valid=%b exp overrun=1 valid=0", overrun, upd_valid);
        end
    endtask

    task automatic test_reset_mid();
        ch_data[2*c_W +: c_W] = 16'h0055;
        ch_load = 3'b100;
        tick();
        ch_load = 3'b000;
        tests_run++; if (upd_valid !== 1'b1) begin tests_failed++; $display("FAIL rmid_pend got=%b exp=1", upd_valid); end
        #3;
        rst = 1'b1;
        #1;
        tests_run++; if (numero_out !== 16'h0000 || sel_ch !== 2'd0 || upd_valid !== 1'b0 || overrun !== 1'b0) begin
            tests_failed++; $display("FAIL rmid_async got numero=%h sel=%0d valid=%b ovr=%b exp 0000/0/0/0", numero_out, sel_ch, upd_valid, overrun);
        end
        tick();
        rst = 1'b0;
        tick();
        tests_run++; if (upd_valid !== 1'b0 || sel_ch !== 2'd0) begin
            tests_failed++; $display("FAIL rmid_release got valid=%b sel=%0d exp 0/0", upd_valid, sel_ch);
        end
    endtask

    task automatic test_timeout();
        ch_data[0*c_W +: c_W] = 16'h0111;
        ch_data[2*c_W +: c_W] = 16'h0222;
        ch_load = 3'b100;
        upd_ready = 1'b1;
        tick();
        ch_load = 3'b000;
        tests_run++; if (sel_ch !== 2'd2 || upd_valid !== 1'b1) begin
            tests_failed++; $display("FAIL to_load got sel=%0d valid=%b exp 2/1", sel_ch, upd_valid);
        end
        tick();
        upd_ready = 1'b0;
        tests_run++; if (upd_valid !== 1'b0) begin tests_failed++; $display("FAIL to_accept got=%b exp=0", upd_valid); end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++; if (sel_ch !== 2'd2 || upd_valid !== 1'b0) begin
                tests_failed++; $display("FAIL to_wait%0d got sel=%0d valid=%b exp 2/0", k, sel_ch, upd_valid);
            end
        end
        // The revert captures whatever channel 0 holds at that moment.
        ch_data[0*c_W +: c_W] = 16'h0333;
        tick();
        tests_run++; if (sel_ch !== 2'd0 || numero_out !== 16'h0333 || upd_valid !== 1'b1) begin
            tests_failed++; $display("FAIL to_revert got sel=%0d numero=%h valid=%b exp 0/0333/1", sel_ch, numero_out, upd_valid);
        end
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
        tests_run++; if (upd_valid !== 1'b0) begin tests_failed++; $display("FAIL to_revert_accept got=%b exp=0", upd_valid); end
    endtask

    task automatic test_collision();
        ch_data[2*c_W +: c_W] = 16'h0222;
        ch_load = 3'b100;
        upd_ready = 1'b1;
        tick();
        ch_load = 3'b000;
        tick();
        upd_ready = 1'b0;
        tick();
        tick();
        tick();
        ch_data[1*c_W +: c_W] = 16'h0077;
        ch_load = 3'b010;
        tick();
        ch_load = 3'b000;
        tests_run++; if (sel_ch !== 2'd1 || numero_out !== 16'h0077 || upd_valid !== 1'b1) begin
            tests_failed++; $display("FAIL coll_sel got sel=%0d numero=%h valid=%b exp 1/0077/1", sel_ch, numero_out, upd_valid);
        end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL coll_overrun got=%b exp=0", overrun); end
        upd_ready = 1'b1;
        tick();
        upd_ready = 1'b0;
    endtask

    task automatic test_load_accept();
        ch_data[2*c_W +: c_W] = 16'h0404;
        ch_load = 3'b100;
        tick();
        ch_data[0*c_W +: c_W] = 16'h0505;
        ch_load = 3'b001;
        upd_ready = 1'b1;
        tick();
        ch_load = 3'b000;
        tests_run++; if (sel_ch !== 2'd0 || numero_out !== 16'h0505 || upd_valid !== 1'b1) begin
            tests_failed++; $display("FAIL la_capture got sel=%0d numero=%h valid=%b exp 0/0505/1", sel_ch, numero_out, upd_valid);
        end
        tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("FAIL la_overrun got=%b exp=0", overrun); end
        tick();
        upd_ready = 1'b0;
        tests_run++; if (upd_valid !== 1'b0) begin tests_failed++; $display("FAIL la_drain got=%b exp=0", upd_valid); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        ch_data      = '0;
        ch_load      = '0;
        upd_ready    = 1'b0;
        test_reset_init();
        test_priority();
        test_handshake();
        test_overrun();
        test_reset_mid();
        test_timeout();
        test_collision();
        test_load_accept();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
